// File: rtl/mcu_arbiter_pkg.sv
// Shared types and constants for the memory control unit arbiter.
package mcu_arbiter_pkg;

    // MEM access size encodings (mem_len_i); 2'b11 behaves as a word.
    localparam logic [1:0] LEN_BYTE = 2'b00;
    localparam logic [1:0] LEN_HALF = 2'b01;
    localparam logic [1:0] LEN_WORD = 2'b10;

    // The RAM data bus is one byte wide.
    typedef logic [7:0] mem_byte_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_RD_LAST,
        ST_WR,
        ST_DONE
    } mcu_state_e;

    // Number of bytes moved by an access of the given size.
    function automatic logic [2:0] len_to_bytes(input logic [1:0] len);
        case (len)
            LEN_BYTE: return 3'd1;
            LEN_HALF: return 3'd2;
            default:  return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mcu_arbiter.sv
// Memory control unit: owns the single-port byte-wide RAM, gives MEM strict
// priority over instruction fetch, and breaks MEM loads/stores into byte accesses.
module mcu_arbiter
    import mcu_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    // Instruction fetch side
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output mem_byte_t         if_data_o,
    output logic              stallreq_if_o,
    // Data access side
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [1:0]        mem_len_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [31:0]       mem_wdata_i,
    output logic [31:0]       mem_rdata_o,
    output logic              mem_done_o,
    output logic              stallreq_mem_o,
    // RAM port
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic              ram_we_o,
    output mem_byte_t         ram_dout_o,
    input  mem_byte_t         ram_din_i
);

    mcu_state_e        state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [2:0]        n_q, n_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;

    logic              if_owns;
    logic [1:0]        cnt_nx;
    logic              last_issue;

    // Index of the next byte to issue, and whether it is the final one.
    assign cnt_nx     = cnt_q + 2'd1;
    assign last_issue = (({1'b0, cnt_q} + 3'd2) == n_q);

    // Next-state, RAM port mux and read-data assembly.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latches).
        state_d    = state_q;
        cnt_d      = cnt_q;
        n_d        = n_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        ram_addr_o = '0;
        ram_we_o   = 1'b0;
        ram_dout_o = '0;
        if_owns    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (mem_req_i) begin
                    // Byte 0 goes out in the accepting cycle.
                    ram_addr_o = mem_addr_i;
                    ram_we_o   = mem_we_i;
                    ram_dout_o = mem_wdata_i[7:0];
                    addr_d     = mem_addr_i;
                    wdata_d    = mem_wdata_i;
                    n_d        = len_to_bytes(mem_len_i);
                    cnt_d      = 2'd0;
                    rdata_d    = '0;
                    if (mem_we_i) begin
                        state_d = (len_to_bytes(mem_len_i) == 3'd1) ? ST_DONE : ST_WR;
                    end else begin
                        state_d = (len_to_bytes(mem_len_i) == 3'd1) ? ST_RD_LAST : ST_RD;
                    end
                end else begin
                    if_owns = 1'b1;
                    if (if_req_i) begin
                        ram_addr_o = if_addr_i;
                    end
                end
            end
            ST_RD: begin
                // Byte cnt arrives while byte cnt+1 is issued.
                ram_addr_o                     = addr_q + ADDR_W'(cnt_nx);
                rdata_d[{cnt_q, 3'b000} +: 8] = ram_din_i;
                cnt_d                          = cnt_nx;
                if (last_issue) begin
                    state_d = ST_RD_LAST;
                end
            end
            ST_RD_LAST: begin
                rdata_d[{cnt_q, 3'b000} +: 8] = ram_din_i;
                state_d                        = ST_DONE;
            end
            ST_WR: begin
                ram_addr_o = addr_q + ADDR_W'(cnt_nx);
                ram_we_o   = 1'b1;
                ram_dout_o = wdata_q[{cnt_nx, 3'b000} +: 8];
                cnt_d      = cnt_nx;
                if (last_issue) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // mem_req_i is still high here; returning to IDLE cannot retrigger this cycle.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign if_data_o      = ram_din_i;
    assign stallreq_if_o  = if_req_i && !if_owns;
    assign mem_done_o     = (state_q == ST_DONE);
    assign mem_rdata_o    = rdata_q;
    assign stallreq_mem_o = mem_req_i && (state_q != ST_DONE);

    // State and access registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 2'd0;
            n_q     <= 3'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_mcu_arbiter.sv
// Directed bench for mcu_arbiter with a 4 KiB byte RAM model (1-cycle read latency).
module tb_mcu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [7:0]  if_data_o;
    logic        stallreq_if_o;
    logic        mem_req_i;
    logic        mem_we_i;
    logic [1:0]  mem_len_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic [31:0] mem_rdata_o;
    logic        mem_done_o;
    logic        stallreq_mem_o;
    logic [31:0] ram_addr_o;
    logic        ram_we_o;
    logic [7:0]  ram_dout_o;
    logic [7:0]  ram_din;

    int checks   = 0;
    int failures = 0;

    logic [7:0] ram [0:4095];

    mcu_arbiter #(.ADDR_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .if_req_i       (if_req_i),
        .if_addr_i      (if_addr_i),
        .if_data_o      (if_data_o),
        .stallreq_if_o  (stallreq_if_o),
        .mem_req_i      (mem_req_i),
        .mem_we_i       (mem_we_i),
        .mem_len_i      (mem_len_i),
        .mem_addr_i     (mem_addr_i),
        .mem_wdata_i    (mem_wdata_i),
        .mem_rdata_o    (mem_rdata_o),
        .mem_done_o     (mem_done_o),
        .stallreq_mem_o (stallreq_mem_o),
        .ram_addr_o     (ram_addr_o),
        .ram_we_o       (ram_we_o),
        .ram_dout_o     (ram_dout_o),
        .ram_din_i      (ram_din)
    );

    always #5 clk = ~clk;

    // RAM model: read-before-write, data returned one cycle after the address.
    always @(posedge clk) begin
        ram_din <= ram[ram_addr_o[11:0]];
        if (ram_we_o) ram[ram_addr_o[11:0]] = ram_dout_o;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench did not terminate");
    end

    initial begin
        rst = 1'b1; if_req_i = 1'b0; if_addr_i = '0;
        mem_req_i = 1'b0; mem_we_i = 1'b0; mem_len_i = 2'b00;
        mem_addr_i = '0; mem_wdata_i = '0;
        for (int i = 0; i < 4096; i++) ram[i] = 8'(i);
        ram[12'h100] = 8'hA0; ram[12'h101] = 8'hA1; ram[12'h102] = 8'hA2; ram[12'h103] = 8'hA3;
        ram[12'h200] = 8'h11; ram[12'h201] = 8'h22; ram[12'h202] = 8'h33; ram[12'h203] = 8'h44;
        ram[12'hFFE] = 8'h9A; ram[12'hFFF] = 8'hBC; ram[12'h000] = 8'hDE; ram[12'h001] = 8'hF0;

        // Reset state
        repeat (2) step();
        check("rst_we",        ram_we_o, 0);
        check("rst_addr",      ram_addr_o, 0);
        check("rst_dout",      ram_dout_o, 0);
        check("rst_done",      mem_done_o, 0);
        check("rst_rdata",     mem_rdata_o, 0);
        check("rst_stall_mem", stallreq_mem_o, 0);
        rst = 1'b0;

        // IF-only streaming fetch 0x100..0x103
        if_req_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if_addr_i = 32'h100 + k;
            settle();
            check("if_stall", stallreq_if_o, 0);
            check("if_addr",  ram_addr_o, 32'h100 + k);
            step();
            check("if_data",  if_data_o, 32'hA0 + k);
        end
        if_req_i = 1'b0;

        // Word load at 0x200: done 5 cycles after request
        mem_req_i = 1'b1; mem_we_i = 1'b0; mem_len_i = 2'b10; mem_addr_i = 32'h200;
        settle();
        check("ld_addr0",     ram_addr_o, 32'h200);
        check("ld_stall_mem", stallreq_mem_o, 1);
        check("ld_done",      mem_done_o, 0);
        for (int k = 1; k <= 4; k++) begin
            step();
            check("ld_done",      mem_done_o, 0);
            check("ld_stall_mem", stallreq_mem_o, 1);
            check("ld_addr",      ram_addr_o, (k < 4) ? 32'h200 + k : 32'h0);
        end
        step();
        check("ld_done_pulse", mem_done_o, 1);
        check("ld_rdata",      mem_rdata_o, 32'h44332211);
        check("ld_stall_rel",  stallreq_mem_o, 0);
        mem_req_i = 1'b0;
        step();
        check("ld_done_low", mem_done_o, 0);

        // Half store 0xBEEF to 0x301: done at cycle 2
        mem_req_i = 1'b1; mem_we_i = 1'b1; mem_len_i = 2'b01;
        mem_addr_i = 32'h301; mem_wdata_i = 32'h0000BEEF;
        settle();
        check("st_we0",   ram_we_o, 1);
        check("st_addr0", ram_addr_o, 32'h301);
        check("st_dout0", ram_dout_o, 32'hEF);
        step();
        check("st_we1",   ram_we_o, 1);
        check("st_addr1", ram_addr_o, 32'h302);
        check("st_dout1", ram_dout_o, 32'hBE);
        check("st_done1", mem_done_o, 0);
        step();
        check("st_done2", mem_done_o, 1);
        check("st_we2",   ram_we_o, 0);
        mem_req_i = 1'b0; mem_we_i = 1'b0;
        step();
        check("st_ram300", ram[12'h300], 32'h00);
        check("st_ram301", ram[12'h301], 32'hEF);
        check("st_ram302", ram[12'h302], 32'hBE);
        check("st_ram303", ram[12'h303], 32'h03);

        // Byte store: IDLE -> DONE directly
        mem_req_i = 1'b1; mem_we_i = 1'b1; mem_len_i = 2'b00;
        mem_addr_i = 32'h310; mem_wdata_i = 32'h1234565A;
        settle();
        check("sb_dout", ram_dout_o, 32'h5A);
        step();
        check("sb_done", mem_done_o, 1);
        mem_req_i = 1'b0; mem_we_i = 1'b0;
        step();
        check("sb_ram310", ram[12'h310], 32'h5A);
        check("sb_ram311", ram[12'h311], 32'h11);

        // IF mid-fetch preempted by a byte load
        if_req_i = 1'b1; if_addr_i = 32'h101;
        settle();
        check("pre_if_stall", stallreq_if_o, 0);
        step();
        check("pre_if_data", if_data_o, 32'hA1);
        if_addr_i = 32'h102;
        mem_req_i = 1'b1; mem_we_i = 1'b0; mem_len_i = 2'b00; mem_addr_i = 32'h203;
        settle();
        check("pre_stall_idle", stallreq_if_o, 1);
        check("pre_mem_addr",   ram_addr_o, 32'h203);
        step();
        check("pre_stall_rdl",  stallreq_if_o, 1);
        check("pre_done_rdl",   mem_done_o, 0);
        step();
        check("pre_stall_done", stallreq_if_o, 1);
        check("pre_done",       mem_done_o, 1);
        check("pre_rdata",      mem_rdata_o, 32'h00000044);
        mem_req_i = 1'b0;
        step();
        check("pre_if_release", stallreq_if_o, 0);
        check("pre_if_addr",    ram_addr_o, 32'h102);
        step();
        check("pre_if_data2",   if_data_o, 32'hA2);
        if_req_i = 1'b0;

        // Word load across the address wrap point
        mem_req_i = 1'b1; mem_we_i = 1'b0; mem_len_i = 2'b10; mem_addr_i = 32'hFFFF_FFFE;
        settle();
        check("wrap_addr0", ram_addr_o, 32'hFFFF_FFFE);
        step();
        check("wrap_addr1", ram_addr_o, 32'hFFFF_FFFF);
        step();
        check("wrap_addr2", ram_addr_o, 32'h0000_0000);
        step();
        check("wrap_addr3", ram_addr_o, 32'h0000_0001);
        repeat (2) step();
        check("wrap_done",  mem_done_o, 1);
        check("wrap_rdata", mem_rdata_o, 32'hF0DEBC9A);
        mem_req_i = 1'b0;
        step();

        // Back-to-back loads with mem_req_i held (len 2'b11 acts as word)
        mem_req_i = 1'b1; mem_we_i = 1'b0; mem_len_i = 2'b11; mem_addr_i = 32'h200;
        settle();
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (cyc > 0) step();
            check("b2b_done", mem_done_o, (cyc == 5 || cyc == 11));
            if (cyc == 0 || cyc == 6) check("b2b_start", ram_addr_o, 32'h200);
            if (cyc == 5) check("b2b_no_retrig", ram_addr_o, 32'h0);
        end
        check("b2b_rdata", mem_rdata_o, 32'h44332211);
        mem_req_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("b2b_quiet_done",  mem_done_o, 0);
            check("b2b_quiet_stall", stallreq_mem_o, 0);
        end

        // Reset during the second WR cycle of a word store
        mem_req_i = 1'b1; mem_we_i = 1'b1; mem_len_i = 2'b10;
        mem_addr_i = 32'h320; mem_wdata_i = 32'hCAFEF00D;
        settle();
        check("rs_dout0", ram_dout_o, 32'h0D);
        step();
        check("rs_addr1", ram_addr_o, 32'h321);
        check("rs_dout1", ram_dout_o, 32'hF0);
        step();
        check("rs_addr2", ram_addr_o, 32'h322);
        check("rs_we2",   ram_we_o, 1);
        rst = 1'b1; mem_req_i = 1'b0; mem_we_i = 1'b0;
        step();
        rst = 1'b0;
        settle();
        check("rs_we_after",    ram_we_o, 0);
        check("rs_addr_after",  ram_addr_o, 0);
        check("rs_stall_after", stallreq_mem_o, 0);
        check("rs_done_after",  mem_done_o, 0);
        for (int k = 0; k < 4; k++) begin
            step();
            check("rs_no_done", mem_done_o, 0);
        end
        check("rs_ram320", ram[12'h320], 32'h0D);
        check("rs_ram321", ram[12'h321], 32'hF0);
        check("rs_ram322", ram[12'h322], 32'hFE);
        check("rs_ram323", ram[12'h323], 32'h23);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
